// File: rtl/data_memory_responder.sv
// Off-chip data memory model for the data cache. It serves one line-granular read or write
// at a time and acknowledges it with a one-cycle pulse a fixed number of cycles after acceptance.
module data_memory_responder #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int unsigned IdxW    = $clog2(DEPTH);
    localparam logic [7:0]  LastCnt = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic              wr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] mem [DEPTH];
    logic              commit;
    logic              unused_addr;

    // Byte offset and bits above the line index never select anything.
    assign unused_addr = ^{addr_i[31:5+IdxW], addr_i[4:0]};

    // The ACK-entry edge: the write lands or the read line is captured.
    assign commit = (state_q == StWait) && (cnt_q == LastCnt);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            ack_o   <= 1'b0;
            data_o  <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack_o <= 1'b0;
                    if (enable_i) begin
                        idx_q   <= addr_i[5 +: IdxW];
                        wr_q    <= write_i;
                        wdata_q <= data_i;
                        cnt_q   <= 8'd1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (commit) begin
                        state_q <= StAck;
                        ack_o   <= 1'b1;
                        if (!wr_q) begin
                            data_o <= mem[idx_q];
                        end
                    end
                end
                StAck: begin
                    ack_o   <= 1'b0;
                    cnt_q   <= 8'd0;
                    state_q <= StIdle;
                end
                default: begin
                    ack_o   <= 1'b0;
                    cnt_q   <= 8'd0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Storage has no reset so its contents survive rst_i; an asserted reset forces
    // state_q to StIdle, which blocks a pending commit.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
